vend_controller: RTL and testbench

Vending-machine transaction controller, directly downstream of the clock divider. Samples the divider's slow toggle output (clk_div) on the system clock and converts each rising edge into a one-cycle second tick. Accumulates coin credit, dispenses once the price is met, and refunds on cancel or inactivity timeout. Output indications are held for a fixed number of seconds, counted on that tick.

---
 rtl/vend_controller.sv | 156 +++++++++++++++
 tb/tb_vend_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending-machine transaction controller.
// Turns rising edges of the divider output into one-cycle second ticks, accumulates
// coin credit, dispenses once the price is met and refunds on cancel or inactivity.
// Dispense/refund indications are held for HOLD_S seconds before returning to idle.
module vend_controller #(
    parameter int unsigned CW        = 8,
    parameter int unsigned PRICE     = 35,
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned HOLD_S    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_div,
    input  logic          coin_5,
    input  logic          coin_10,
    input  logic          coin_25,
    input  logic          cancel,
    output logic [CW-1:0] credit,
    output logic          dispense,
    output logic          refund,
    output logic [CW-1:0] change_out,
    output logic          coin_reject,
    output logic          busy
);

    localparam int unsigned MaxS = (TIMEOUT_S > HOLD_S) ? TIMEOUT_S : HOLD_S;
    localparam int unsigned SW   = $clog2(MaxS + 1);

    localparam logic [SW-1:0] TimeoutCnt = SW'(TIMEOUT_S);
    localparam logic [SW-1:0] HoldCnt    = SW'(HOLD_S);
    localparam logic [CW-1:0] PriceCw    = CW'(PRICE);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDispense,
        StReturn
    } state_e;

    state_e        state_q;
    logic          clk_div_q;
    logic [SW-1:0] sec_cnt_q;

    logic          tick;
    logic          coin_any;
    logic [CW:0]   coin_sum;
    logic [CW:0]   credit_raw;
    logic [CW-1:0] credit_sat;
    logic [SW-1:0] sec_inc;

    // Tick detection, coin summation and saturating credit update.
    always_comb begin
        tick     = clk_div & ~clk_div_q;
        coin_any = coin_5 | coin_10 | coin_25;
        coin_sum = '0;
        if (coin_5) begin
            coin_sum = coin_sum + (CW+1)'(5);
        end
        if (coin_10) begin
            coin_sum = coin_sum + (CW+1)'(10);
        end
        if (coin_25) begin
            coin_sum = coin_sum + (CW+1)'(25);
        end
        credit_raw = {1'b0, credit} + coin_sum;
        // Carry out of the CW-bit range means the credit saturates at all-ones.
        credit_sat = credit_raw[CW] ? {CW{1'b1}} : credit_raw[CW-1:0];
        sec_inc    = sec_cnt_q + SW'(1);
    end

    // Divider edge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_div_q <= 1'b0;
        end else begin
            clk_div_q <= clk_div;
        end
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sec_cnt_q   <= '0;
            credit      <= '0;
            dispense    <= 1'b0;
            refund      <= 1'b0;
            change_out  <= '0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (coin_any) begin
                        credit    <= credit_sat;
                        sec_cnt_q <= '0;
                        state_q   <= StCollect;
                    end
                end
                StCollect: begin
                    credit <= credit_sat;
                    if (credit_sat >= PriceCw) begin
                        state_q    <= StDispense;
                        change_out <= credit_sat - PriceCw;
                        dispense   <= 1'b1;
                        busy       <= 1'b1;
                        sec_cnt_q  <= '0;
                    end else if (cancel) begin
                        // A coin arriving together with cancel is refunded too.
                        state_q    <= StReturn;
                        change_out <= credit_sat;
                        refund     <= 1'b1;
                        busy       <= 1'b1;
                        sec_cnt_q  <= '0;
                    end else if (coin_any) begin
                        // Coin activity restarts the inactivity window, even on a tick.
                        sec_cnt_q <= '0;
                    end else if (tick) begin
                        if (sec_inc == TimeoutCnt) begin
                            state_q    <= StReturn;
                            change_out <= credit;
                            refund     <= 1'b1;
                            busy       <= 1'b1;
                            sec_cnt_q  <= '0;
                        end else begin
                            sec_cnt_q <= sec_inc;
                        end
                    end
                end
                StDispense, StReturn: begin
                    if (coin_any) begin
                        coin_reject <= 1'b1;
                    end
                    if (tick) begin
                        if (sec_inc == HoldCnt) begin
                            state_q    <= StIdle;
                            credit     <= '0;
                            change_out <= '0;
                            dispense   <= 1'b0;
                            refund     <= 1'b0;
                            busy       <= 1'b0;
                            sec_cnt_q  <= '0;
                        end else begin
                            sec_cnt_q <= sec_inc;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios followed by randomized
// coin/cancel/divider traffic, all compared against a transaction-level reference model.
module tb_vend_controller;

    localparam int unsigned CW        = 8;
    localparam int unsigned PRICE     = 35;
    localparam int unsigned TIMEOUT_S = 10;
    localparam int unsigned HOLD_S    = 3;
    localparam int          CREDIT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_div = 1'b0;
    logic          coin_5 = 1'b0;
    logic          coin_10 = 1'b0;
    logic          coin_25 = 1'b0;
    logic          cancel = 1'b0;
    logic [CW-1:0] credit;
    logic          dispense;
    logic          refund;
    logic [CW-1:0] change_out;
    logic          coin_reject;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the customer sees, in plain integers.
    // m_activity: 0 waiting for first coin, 1 paying, 2 vending, 3 refunding.
    int m_activity;
    int m_credit;
    int m_change;
    int m_quiet_s;
    int m_shown_s;
    bit m_reject;
    bit m_div_prev;

    vend_controller #(
        .CW        (CW),
        .PRICE     (PRICE),
        .TIMEOUT_S (TIMEOUT_S),
        .HOLD_S    (HOLD_S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_div     (clk_div),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .coin_25     (coin_25),
        .cancel      (cancel),
        .credit      (credit),
        .dispense    (dispense),
        .refund      (refund),
        .change_out  (change_out),
        .coin_reject (coin_reject),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_activity = 0;
        m_credit   = 0;
        m_change   = 0;
        m_quiet_s  = 0;
        m_shown_s  = 0;
        m_reject   = 1'b0;
        m_div_prev = 1'b0;
    endtask

    task automatic model_step(input bit c5, input bit c10, input bit c25, input bit cn,
                              input bit div);
        int  paid;
        int  total;
        bit  second;
        paid       = 5 * int'(c5) + 10 * int'(c10) + 25 * int'(c25);
        second     = div && !m_div_prev;
        m_div_prev = div;
        m_reject   = 1'b0;
        if (m_activity == 0) begin
            if (paid > 0) begin
                m_credit   = (paid > CREDIT_MAX) ? CREDIT_MAX : paid;
                m_quiet_s  = 0;
                m_activity = 1;
            end
        end else if (m_activity == 1) begin
            total    = m_credit + paid;
            m_credit = (total > CREDIT_MAX) ? CREDIT_MAX : total;
            if (m_credit >= PRICE) begin
                m_activity = 2;
                m_change   = m_credit - PRICE;
                m_shown_s  = 0;
            end else if (cn) begin
                m_activity = 3;
                m_change   = m_credit;
                m_shown_s  = 0;
            end else if (paid > 0) begin
                m_quiet_s = 0;
            end else if (second) begin
                m_quiet_s++;
                if (m_quiet_s == TIMEOUT_S) begin
                    m_activity = 3;
                    m_change   = m_credit;
                    m_shown_s  = 0;
                end
            end
        end else begin
            if (paid > 0) begin
                m_reject = 1'b1;
            end
            if (second) begin
                m_shown_s++;
                if (m_shown_s == HOLD_S) begin
                    m_activity = 0;
                    m_credit   = 0;
                    m_change   = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string where);
        bit showing;
        showing = (m_activity >= 2);
        check({where, ".credit"}, int'(credit), m_credit);
        check({where, ".dispense"}, int'(dispense), int'(m_activity == 2));
        check({where, ".refund"}, int'(refund), int'(m_activity == 3));
        check({where, ".change_out"}, int'(change_out), showing ? m_change : 0);
        check({where, ".coin_reject"}, int'(coin_reject), int'(m_reject));
        check({where, ".busy"}, int'(busy), int'(showing));
    endtask

    // One clock cycle: called at posedge+1, drives inputs, samples at next posedge+1.
    task automatic cycle(input bit c5, input bit c10, input bit c25, input bit cn,
                         input string where);
        coin_5  = c5;
        coin_10 = c10;
        coin_25 = c25;
        cancel  = cn;
        model_step(c5, c10, c25, cn, clk_div);
        @(posedge clk);
        #1;
        coin_5  = 1'b0;
        coin_10 = 1'b0;
        coin_25 = 1'b0;
        cancel  = 1'b0;
        check_outputs(where);
    endtask

    task automatic idle_cycles(input int n, input string where);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, where);
        end
    endtask

    // One second: a divider rising edge followed by a low phase.
    task automatic one_second(input string where);
        clk_div = 1'b1;
        idle_cycles(2, where);
        clk_div = 1'b0;
        idle_cycles(2, where);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must drop immediately.
    task automatic async_reset(input string where);
        rst = 1'b1;
        #1;
        check({where, ".rst_credit"}, int'(credit), 0);
        check({where, ".rst_dispense"}, int'(dispense), 0);
        check({where, ".rst_refund"}, int'(refund), 0);
        check({where, ".rst_change"}, int'(change_out), 0);
        check({where, ".rst_reject"}, int'(coin_reject), 0);
        check({where, ".rst_busy"}, int'(busy), 0);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    int div_period;
    int div_cnt;
    int act;

    initial begin
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Exact price in two coins, then hold for three seconds.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "t1_c25");
        check("t1_credit25", int'(credit), 25);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t1_c10");
        check("t1_credit35", int'(credit), 35);
        check("t1_dispense", int'(dispense), 1);
        check("t1_change0", int'(change_out), 0);
        for (int s = 0; s < 3; s++) one_second("t1_hold");
        check("t1_idle_credit", int'(credit), 0);
        check("t1_idle_dispense", int'(dispense), 0);

        // Overpay with two quarters.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "t2_c25a");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "t2_c25b");
        check("t2_change15", int'(change_out), 15);
        for (int s = 0; s < 3; s++) one_second("t2_hold");

        // Cancel together with a coin refunds both.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "t3_c5");
        cycle(1'b0, 1'b1, 1'b0, 1'b1, "t3_cancel");
        check("t3_refund", int'(refund), 1);
        check("t3_change15", int'(change_out), 15);
        for (int s = 0; s < 3; s++) one_second("t3_hold");
        check("t3_idle_busy", int'(busy), 0);

        // Inactivity timeout.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t4_c10");
        for (int s = 0; s < 10; s++) one_second("t4_wait");
        check("t4_timeout_refund", int'(refund), 1);
        check("t4_timeout_change", int'(change_out), 10);
        for (int s = 0; s < 3; s++) one_second("t4_hold");

        // Coin on the ninth tick restarts the timeout window.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t5_c10");
        for (int s = 0; s < 8; s++) one_second("t5_wait");
        clk_div = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "t5_tick9_coin");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "t5_tick9_hi");
        clk_div = 1'b0;
        idle_cycles(2, "t5_tick9_lo");
        for (int s = 0; s < 9; s++) one_second("t5_rewait");
        check("t5_no_refund_yet", int'(refund), 0);
        check("t5_credit15", int'(credit), 15);
        one_second("t5_last");
        check("t5_refund", int'(refund), 1);
        check("t5_change15", int'(change_out), 15);
        for (int s = 0; s < 3; s++) one_second("t5_hold");

        // All three coins at once, then a rejected coin during dispense.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, "t6_all");
        check("t6_credit40", int'(credit), 40);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "t6_enter");
        check("t6_change5", int'(change_out), 5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t6_reject");
        check("t6_reject_pulse", int'(coin_reject), 1);
        check("t6_change_kept", int'(change_out), 5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "t6_after");
        check("t6_reject_gone", int'(coin_reject), 0);
        for (int s = 0; s < 3; s++) one_second("t6_hold");

        // Reset during refund of 20, then a fresh coin.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t7_c10a");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t7_c10b");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "t7_cancel");
        check("t7_change20", int'(change_out), 20);
        async_reset("t7");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "t7_c5");
        check("t7_credit5", int'(credit), 5);
        idle_cycles(1, "t7_settle");

        // Randomized traffic in blocks of varying coin activity.
        div_period = 4;
        div_cnt    = 0;
        for (int blk = 0; blk < 30; blk++) begin
            act        = int'($urandom_range(0, 3));
            div_period = int'($urandom_range(2, 5));
            for (int i = 0; i < 200; i++) begin
                bit r5;
                bit r10;
                bit r25;
                bit rcn;
                r5  = ($urandom_range(0, 99) < act * 3);
                r10 = ($urandom_range(0, 99) < act * 3);
                r25 = ($urandom_range(0, 99) < act * 2);
                rcn = ($urandom_range(0, 99) < act);
                div_cnt++;
                if (div_cnt >= div_period) begin
                    div_cnt = 0;
                    clk_div = ~clk_div;
                end
                if ($urandom_range(0, 999) == 0) begin
                    async_reset("rnd");
                end
                cycle(r5, r10, r25, rcn, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
